// File: rtl/button_event_rx_if.sv
// Event bundle from the pushbutton receiver to the LED/pattern control logic.
// master = receiver that drives the events, slave = consumer.
interface button_event_rx_if;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_press;
  logic       long_press;
  logic [7:0] press_count;

  modport master (
    output btn_level,
    output press_pulse,
    output release_pulse,
    output short_press,
    output long_press,
    output press_count
  );

  modport slave (
    input btn_level,
    input press_pulse,
    input release_pulse,
    input short_press,
    input long_press,
    input press_count
  );
endinterface

// File: rtl/button_event_rx.sv
// Pushbutton receiver: 2-FF synchronizer, debounce FSM and hold-time classification
// into one-cycle press/release/short/long events plus a wrapping press counter.
module button_event_rx #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 12000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                hw_clk,
  input  logic                rst_n,
  input  logic                btn_pin,
  button_event_rx_if.master   ev
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_CHK,
    PRESSED,
    LONG,
    REL_CHK
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          long_seen_q, long_seen_d;
  logic          btn_level_q, btn_level_d;
  logic          press_pulse_q, press_pulse_d;
  logic          release_pulse_q, release_pulse_d;
  logic          short_press_q, short_press_d;
  logic          long_press_q, long_press_d;
  logic [7:0]    press_count_q, press_count_d;
  logic          pressed;

  assign pressed = sync2_q ^ ACTIVE_LOW;

  always_comb begin
    state_d         = state_q;
    dcnt_d          = dcnt_q;
    hcnt_d          = hcnt_q;
    long_seen_d     = long_seen_q;
    btn_level_d     = btn_level_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    short_press_d   = 1'b0;
    long_press_d    = 1'b0;
    press_count_d   = press_count_q;

    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS_CHK;
          dcnt_d  = '0;
        end
      end
      PRESS_CHK: begin
        if (!pressed) begin
          state_d = IDLE;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d       = PRESSED;
          btn_level_d   = 1'b1;
          press_pulse_d = 1'b1;
          press_count_d = press_count_q + 8'd1;
          hcnt_d        = '0;
          long_seen_d   = 1'b0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_d = REL_CHK;
          dcnt_d  = '0;
        end else if (hcnt_q == HCNT_LAST) begin
          state_d      = LONG;
          long_press_d = 1'b1;
          long_seen_d  = 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      LONG: begin
        if (!pressed) begin
          state_d = REL_CHK;
          dcnt_d  = '0;
        end
      end
      REL_CHK: begin
        // A release bounce returns to the held state with hcnt untouched.
        if (pressed) begin
          state_d = long_seen_q ? LONG : PRESSED;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d         = IDLE;
          btn_level_d     = 1'b0;
          release_pulse_d = 1'b1;
          short_press_d   = !long_seen_q;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q         <= ACTIVE_LOW;
      sync2_q         <= ACTIVE_LOW;
      state_q         <= IDLE;
      dcnt_q          <= '0;
      hcnt_q          <= '0;
      long_seen_q     <= 1'b0;
      btn_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      short_press_q   <= 1'b0;
      long_press_q    <= 1'b0;
      press_count_q   <= 8'd0;
    end else begin
      sync1_q         <= btn_pin;
      sync2_q         <= sync1_q;
      state_q         <= state_d;
      dcnt_q          <= dcnt_d;
      hcnt_q          <= hcnt_d;
      long_seen_q     <= long_seen_d;
      btn_level_q     <= btn_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      short_press_q   <= short_press_d;
      long_press_q    <= long_press_d;
      press_count_q   <= press_count_d;
    end
  end

  assign ev.btn_level     = btn_level_q;
  assign ev.press_pulse   = press_pulse_q;
  assign ev.release_pulse = release_pulse_q;
  assign ev.short_press   = short_press_q;
  assign ev.long_press    = long_press_q;
  assign ev.press_count   = press_count_q;

endmodule

// File: tb/tb_button_event_rx.sv
// Bench for button_event_rx: an active-low and an active-high instance see the same
// logical press stream and are both compared each cycle against a run-length model.
module tb_button_event_rx;

  localparam int DEB = 4;
  localparam int LNG = 20;

  logic hw_clk = 1'b0;
  logic rst_n  = 1'b0;
  logic pin_al = 1'b1;
  logic pin_ah = 1'b0;

  always #5 hw_clk = ~hw_clk;

  button_event_rx_if ev_al();
  button_event_rx_if ev_ah();

  button_event_rx #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG), .ACTIVE_LOW(1'b1)) dut_al (
    .hw_clk  (hw_clk),
    .rst_n   (rst_n),
    .btn_pin (pin_al),
    .ev      (ev_al)
  );

  button_event_rx #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG), .ACTIVE_LOW(1'b0)) dut_ah (
    .hw_clk  (hw_clk),
    .rst_n   (rst_n),
    .btn_pin (pin_ah),
    .ev      (ev_ah)
  );

  int errors = 0;
  int checks = 0;

  // Model state: pressed-level history through the synchronizer, accepted level,
  // length of the current run of samples disagreeing with it, and hold ticks.
  bit       m_h1, m_h2, m_level, m_long_seen;
  int       m_run, m_ticks, m_count;
  bit       e_press, e_rel, e_short, e_long;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_h1 = 0; m_h2 = 0; m_level = 0; m_long_seen = 0;
    m_run = 0; m_ticks = 0; m_count = 0;
    e_press = 0; e_rel = 0; e_short = 0; e_long = 0;
  endtask

  task automatic modelStep(input bit p);
    bit s;
    s    = m_h2;
    m_h2 = m_h1;
    m_h1 = p;
    e_press = 0; e_rel = 0; e_short = 0; e_long = 0;
    // Hold time advances only on held samples that are not ending a release bounce.
    if (m_level && s && m_run == 0 && !m_long_seen) begin
      m_ticks++;
      if (m_ticks == LNG) begin
        e_long      = 1;
        m_long_seen = 1;
      end
    end
    if (s != m_level) begin
      m_run++;
      if (m_run == DEB + 1) begin
        m_run = 0;
        if (s) begin
          m_level     = 1;
          e_press     = 1;
          m_count     = (m_count + 1) % 256;
          m_ticks     = 0;
          m_long_seen = 0;
        end else begin
          m_level = 0;
          e_rel   = 1;
          e_short = !m_long_seen;
        end
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, "/al/level"},   32'(ev_al.btn_level),     32'(m_level));
    checkOutput({tag, "/al/press"},   32'(ev_al.press_pulse),   32'(e_press));
    checkOutput({tag, "/al/release"}, 32'(ev_al.release_pulse), 32'(e_rel));
    checkOutput({tag, "/al/short"},   32'(ev_al.short_press),   32'(e_short));
    checkOutput({tag, "/al/long"},    32'(ev_al.long_press),    32'(e_long));
    checkOutput({tag, "/al/count"},   32'(ev_al.press_count),   32'(m_count));
    checkOutput({tag, "/ah/level"},   32'(ev_ah.btn_level),     32'(m_level));
    checkOutput({tag, "/ah/press"},   32'(ev_ah.press_pulse),   32'(e_press));
    checkOutput({tag, "/ah/release"}, 32'(ev_ah.release_pulse), 32'(e_rel));
    checkOutput({tag, "/ah/short"},   32'(ev_ah.short_press),   32'(e_short));
    checkOutput({tag, "/ah/long"},    32'(ev_ah.long_press),    32'(e_long));
    checkOutput({tag, "/ah/count"},   32'(ev_ah.press_count),   32'(m_count));
  endtask

  task automatic applyStimulus(input bit pressed);
    pin_al = ~pressed;
    pin_ah = pressed;
    @(posedge hw_clk);
    #1;
    modelStep(pressed);
    compareAll("cyc");
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "/al/any"}, {26'd0, ev_al.btn_level, ev_al.press_pulse, ev_al.release_pulse,
                ev_al.short_press, ev_al.long_press, 1'b0}, 32'd0);
    checkOutput({tag, "/al/count"}, 32'(ev_al.press_count), 32'd0);
    checkOutput({tag, "/ah/any"}, {26'd0, ev_ah.btn_level, ev_ah.press_pulse, ev_ah.release_pulse,
                ev_ah.short_press, ev_ah.long_press, 1'b0}, 32'd0);
    checkOutput({tag, "/ah/count"}, 32'(ev_ah.press_count), 32'd0);
  endtask

  // Asynchronous reset between edges, released with the pin in the released state.
  task automatic doReset(input string tag);
    rst_n = 1'b0;
    #1;
    checkAllZero(tag);
    modelReset();
    pin_al = 1'b1;
    pin_ah = 1'b0;
    repeat (3) begin
      @(posedge hw_clk);
      #1;
      checkAllZero({tag, "_held"});
    end
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int press_edge, rel_edge, short_edge, long_edge;
    int n_press, n_rel, n_short, n_long;
    bit level_dropped;

    modelReset();
    #1;
    checkAllZero("reset");
    repeat (2) @(posedge hw_clk);
    #3;
    rst_n = 1'b1;
    repeat (5) applyStimulus(0);

    // Clean press held 10 cycles, then released.
    press_edge = 0; rel_edge = 0; short_edge = 0; n_long = 0;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1);
      if (ev_al.press_pulse) press_edge = i;
    end
    checkOutput("clean_press_edge", 32'(press_edge), 32'd7);
    checkOutput("clean_count", 32'(ev_al.press_count), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0);
      if (ev_al.release_pulse) rel_edge = i;
      if (ev_al.short_press) short_edge = i;
      if (ev_al.long_press) n_long++;
    end
    checkOutput("clean_release_edge", 32'(rel_edge), 32'd7);
    checkOutput("clean_short_edge", 32'(short_edge), 32'd7);
    checkOutput("clean_no_long", 32'(n_long), 32'd0);

    // Bounce: 3 pressed, 2 released, five times.
    n_press = 0;
    for (int r = 0; r < 5; r++) begin
      repeat (3) begin applyStimulus(1); n_press += ev_al.press_pulse + ev_ah.press_pulse; end
      repeat (2) begin applyStimulus(0); n_press += ev_al.press_pulse + ev_ah.press_pulse; end
    end
    repeat (8) applyStimulus(0);
    checkOutput("bounce_no_press", 32'(n_press), 32'd0);
    checkOutput("bounce_count", 32'(ev_al.press_count), 32'd1);

    // Long press: 40 cycles held.
    long_edge = 0; n_long = 0; n_short = 0; n_rel = 0;
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(1);
      if (ev_al.long_press) begin long_edge = i; n_long++; end
    end
    checkOutput("long_edge", 32'(long_edge), 32'd27);
    checkOutput("long_once", 32'(n_long), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0);
      n_short += ev_al.short_press;
      n_rel   += ev_al.release_pulse;
    end
    checkOutput("long_release", 32'(n_rel), 32'd1);
    checkOutput("long_no_short", 32'(n_short), 32'd0);

    // Release glitch mid-hold must not drop the level.
    n_rel = 0; n_long = 0; level_dropped = 0;
    repeat (12) applyStimulus(1);
    repeat (2) begin applyStimulus(0); n_rel += ev_al.release_pulse; end
    repeat (30) begin
      applyStimulus(1);
      n_rel += ev_al.release_pulse;
      n_long += ev_al.long_press;
      if (!ev_al.btn_level) level_dropped = 1;
    end
    checkOutput("glitch_no_release", 32'(n_rel), 32'd0);
    checkOutput("glitch_level_held", 32'(level_dropped), 32'd0);
    checkOutput("glitch_long_once", 32'(n_long), 32'd1);
    repeat (10) applyStimulus(0);

    // Randomized segments of bounces, short holds and long holds.
    for (int seg = 0; seg < 200; seg++) begin
      int len;
      case ($urandom_range(0, 2))
        0:       len = $urandom_range(1, 6);
        1:       len = $urandom_range(5, 12);
        default: len = $urandom_range(18, 30);
      endcase
      repeat (len) applyStimulus(seg[0]);
    end
    repeat (10) applyStimulus(0);

    // Counter wrap after 256 clean presses.
    doReset("reset_pre_wrap");
    repeat (3) applyStimulus(0);
    repeat (256) begin
      repeat (6) applyStimulus(1);
      repeat (6) applyStimulus(0);
    end
    checkOutput("wrap_count_al", 32'(ev_al.press_count), 32'd0);
    checkOutput("wrap_count_ah", 32'(ev_ah.press_count), 32'd0);

    // Reset while held, then released pin: no pulses afterwards.
    repeat (9) applyStimulus(1);
    checkOutput("pre_reset_level", 32'(ev_al.btn_level), 32'd1);
    doReset("reset_mid");
    repeat (20) applyStimulus(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
